codec_output_stage: RTL and testbench
=====================================

Name: codec_output_stage

Overview:
Downstream neighbour of the echo stage. It takes each signed 16-bit sample on its ready strobe, applies a per-sample ramped gain with mute fade-out/fade-in, saturates the result and presents a registered sample plus a one-cycle valid pulse to the codec interface. The ramp removes the clicks caused by abrupt volume changes or mute toggles.

Parameters:
WIDTH, 16, sample width in bits; samples are signed two's complement.
GAIN_W, 5, gain register width; gain is unsigned 0..31.
GAIN_FRAC, 4, fractional bits of gain; 16 = unity, 31 = ~1.94x boost.

Ports:
clk  in  1  system clock; the only clock.
reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
sample_in  in  WIDTH  signed sample from the echo stage (its sample_to_codec).
new_sample_ready  in  1  level from the codec; may stay high for many cycles; the block acts on its rising edge only.
target_gain  in  GAIN_W  requested gain; may change at any time.
mute  in  1  level; when 1, the effective target is 0.
sample_to_codec  out  WIDTH  registered scaled and saturated sample.
sample_valid  out  1  one-cycle pulse when sample_to_codec updates.
current_gain  out  GAIN_W  gain currently applied.
muted  out  1  high when state is MUTED.

Behaviour:
- Reset (reset_n=0 at a clk edge): sample_to_codec=0, sample_valid=0, current_gain=0, edge-detect register=0, pipeline regs=0, state=MUTED, muted=1.
- Reset mid-operation aborts any in-flight sample; no valid pulse follows. After release, the gain ramps up from 0 (soft start).
- Strobe: asserted in cycle t when new_sample_ready=1 and its registered copy=0.
  - Exactly one strobe per rising edge, regardless of how long the level is held.
- eff_target = mute ? 0 : target_gain, sampled combinationally in the strobe cycle.
- Pipeline:
  - t: product = sample_in × current_gain (value in cycle t), 21-bit signed, registered at t+1.
  - t+1: arithmetic shift right by GAIN_FRAC (floor, toward -inf), then saturate.
  - Saturation: > 32767 → 16'h7FFF; < -32768 → 16'h8000.
  - Result registered into sample_to_codec with sample_valid=1 at t+2; sample_valid=0 otherwise.
- Fixed latency of 2 cycles from strobe to valid. Strobes must be ≥3 cycles apart (codec rate guarantees this); no back-pressure.
- Gain ramp: at each strobe, current_gain steps by exactly 1 toward eff_target; unchanged if equal. The new value is visible from t+1 and first applies to the next strobe.
- Target/mute changes between strobes affect only the next step. A change in the strobe cycle itself is used for that strobe's step.
- FSM, re-evaluated every cycle from current_gain and eff_target:
  - MUTED: current_gain=0 and eff_target=0.
  - PLAY: current_gain=eff_target≠0.
  - RAMP_UP: current_gain<eff_target.
  - RAMP_DOWN: current_gain>eff_target.
  - State is registered, so it lags inputs by one cycle. muted = (state==MUTED).
- Gain 0 outputs 0 for every sample, including 16'h8000. No wrap-around is possible: gain is clamped to 0..31 by construction of the step.

Decomposition:
- Shared audio package: SAMPLE_W=16, GAIN_W=5, GAIN_FRAC=4, GAIN_UNITY=16, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000, and the 2-bit state encoding (MUTED, RAMP_UP, PLAY, RAMP_DOWN).
- One combinational sub-module, sat_shift: takes the 21-bit product and returns the shifted, saturated 16-bit sample. The top level holds the edge detect, gain ramp, FSM and pipeline registers.

Test Plan:
1. Reset release, target_gain=16, mute=0, 20 strobes with sample_in=16'h1000:
   - outputs 0, 16'h0100, 16'h0200, ..., reaching 16'h1000 from strobe 17;
   - current_gain=16, state PLAY, valid exactly 2 cycles after each strobe.
2. Gain held at 8: sample 16'h8000 → 16'hC000; 16'h0003 → 16'h0001; 16'hFFFF → 16'hFFFF (floor); 16'h7FFF → 16'h3FFF.
3. Gain ramped to 31: 16'h7000 → 16'h7FFF (saturated); 16'h9000 → 16'h8000 (saturated); 16'h0010 → 16'h001F.
4. At gain 16, raise mute:
   - 16 strobes step the gain to 0, then muted=1 and outputs are 0.
   - Drop mute: RAMP_UP, gain=1 after the next strobe.
5. new_sample_ready held high for 10 cycles, then low, then high again: exactly two sample_valid pulses and two gain steps.
6. reset_n=0 for one cycle between a strobe and its t+2:
   - no valid pulse; sample_to_codec=0, current_gain=0, muted=1 from the next cycle.

Source files
------------

// File: rtl/codec_output_stage_pkg.sv
// Shared audio definitions for the codec output stage: sample/gain geometry,
// saturation limits and the gain-ramp state encoding.
package codec_output_stage_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 5;
  localparam int GAIN_FRAC  = 4;
  localparam int GAIN_UNITY = 16;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_MUTED     = 2'b00,
    ST_RAMP_UP   = 2'b01,
    ST_PLAY      = 2'b10,
    ST_RAMP_DOWN = 2'b11
  } gain_state_e;

endpackage

// File: rtl/codec_output_stage_sat_shift.sv
// Combinational rescale of a gain product: floor shift by the gain fraction,
// then clamp into the signed output sample range.
module sat_shift #(
  parameter int PROD_W = 21,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 4
) (
  input  logic signed [PROD_W-1:0] product,
  output logic        [OUT_W-1:0]  sample
);

  localparam logic signed [PROD_W-1:0] MAX_V = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] MIN_V = {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [PROD_W-1:0] shifted_s;

  // Arithmetic shift rounds toward -inf; clamp anything outside the sample range.
  always_comb begin
    shifted_s = product >>> SHIFT;
    if (shifted_s > MAX_V) begin
      sample = MAX_V[OUT_W-1:0];
    end else if (shifted_s < MIN_V) begin
      sample = MIN_V[OUT_W-1:0];
    end else begin
      sample = shifted_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/codec_output_stage.sv
// Codec output stage: ramped per-sample gain with mute fade, saturation and a
// registered sample plus one-cycle valid pulse, two cycles after each strobe.
module codec_output_stage #(
  parameter int WIDTH     = codec_output_stage_pkg::SAMPLE_W,
  parameter int GAIN_W    = codec_output_stage_pkg::GAIN_W,
  parameter int GAIN_FRAC = codec_output_stage_pkg::GAIN_FRAC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              new_sample_ready,
  input  logic [GAIN_W-1:0] target_gain,
  input  logic              mute,
  output logic [WIDTH-1:0]  sample_to_codec,
  output logic              sample_valid,
  output logic [GAIN_W-1:0] current_gain,
  output logic              muted
);

  import codec_output_stage_pkg::*;

  localparam int PROD_W = WIDTH + GAIN_W;

  logic                     nsr_r;
  logic                     strobe_s;
  logic [GAIN_W-1:0]        eff_target_s;
  logic [GAIN_W-1:0]        gain_r;
  logic [GAIN_W-1:0]        gain_next_s;
  logic signed [PROD_W-1:0] samp_ext_s;
  logic signed [PROD_W-1:0] gain_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] prod_r;
  logic                     stage_vld_r;
  logic [WIDTH-1:0]         sat_s;
  gain_state_e              state_r;
  gain_state_e              state_next_s;

  // Rising-edge strobe and the effective gain target.
  always_comb begin
    strobe_s     = new_sample_ready & ~nsr_r;
    eff_target_s = mute ? {GAIN_W{1'b0}} : target_gain;
  end

  // One-step gain ramp toward the target; the step can never leave 0..max.
  always_comb begin
    gain_next_s = gain_r;
    if (strobe_s && (gain_r < eff_target_s)) begin
      gain_next_s = gain_r + {{(GAIN_W-1){1'b0}}, 1'b1};
    end else if (strobe_s && (gain_r > eff_target_s)) begin
      gain_next_s = gain_r - {{(GAIN_W-1){1'b0}}, 1'b1};
    end else begin
      gain_next_s = gain_r;
    end
  end

  // Signed sample times unsigned gain; the result always fits in PROD_W bits.
  always_comb begin
    samp_ext_s = PROD_W'($signed(sample_in));
    gain_ext_s = PROD_W'({1'b0, gain_r});
    prod_s     = samp_ext_s * gain_ext_s;
  end

  // State follows the current gain/target relation, one cycle late.
  always_comb begin
    state_next_s = ST_MUTED;
    if (gain_r < eff_target_s) begin
      state_next_s = ST_RAMP_UP;
    end else if (gain_r > eff_target_s) begin
      state_next_s = ST_RAMP_DOWN;
    end else if (gain_r == {GAIN_W{1'b0}}) begin
      state_next_s = ST_MUTED;
    end else begin
      state_next_s = ST_PLAY;
    end
  end

  sat_shift #(
    .PROD_W (PROD_W),
    .OUT_W  (WIDTH),
    .SHIFT  (GAIN_FRAC)
  ) u_sat_shift (
    .product (prod_r),
    .sample  (sat_s)
  );

  // Edge detect, gain register and ramp state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nsr_r   <= 1'b0;
      gain_r  <= {GAIN_W{1'b0}};
      state_r <= ST_MUTED;
    end else begin
      nsr_r   <= new_sample_ready;
      gain_r  <= gain_next_s;
      state_r <= state_next_s;
    end
  end

  // Two-stage sample pipeline; reset drops any sample in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_r          <= {PROD_W{1'b0}};
      stage_vld_r     <= 1'b0;
      sample_to_codec <= {WIDTH{1'b0}};
      sample_valid    <= 1'b0;
    end else begin
      prod_r          <= strobe_s ? prod_s : prod_r;
      stage_vld_r     <= strobe_s;
      sample_to_codec <= stage_vld_r ? sat_s : sample_to_codec;
      sample_valid    <= stage_vld_r;
    end
  end

  assign current_gain = gain_r;
  assign muted        = (state_r == ST_MUTED);

endmodule

// File: tb/tb_codec_output_stage.sv
// Directed self-checking bench for codec_output_stage: soft start, gain
// scaling with floor/saturation, mute fade, level-held strobe and mid-flight reset.
module tb_codec_output_stage;

  logic        clk;
  logic        reset_n;
  logic [15:0] sample_in;
  logic        new_sample_ready;
  logic [4:0]  target_gain;
  logic        mute;
  logic [15:0] sample_to_codec;
  logic        sample_valid;
  logic [4:0]  current_gain;
  logic        muted;

  int checks = 0;
  int errors = 0;
  int pulses;

  codec_output_stage dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sample_in        (sample_in),
    .new_sample_ready (new_sample_ready),
    .target_gain      (target_gain),
    .mute             (mute),
    .sample_to_codec  (sample_to_codec),
    .sample_valid     (sample_valid),
    .current_gain     (current_gain),
    .muted            (muted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: one strobe, output checked exactly 2 edges later.
  task automatic strobe(input string tag, input logic [15:0] samp, input logic [15:0] exp_out);
    sample_in        = samp;
    new_sample_ready = 1'b1;
    @(negedge clk);
    new_sample_ready = 1'b0;
    chk({tag, "_v_t1"}, 32'(sample_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_v_t2"}, 32'(sample_valid), 32'd1);
    chk({tag, "_data"}, 32'(sample_to_codec), 32'(exp_out));
    @(negedge clk);
    chk({tag, "_v_t3"}, 32'(sample_valid), 32'd0);
  endtask

  initial begin
    reset_n          = 1'b0;
    sample_in        = 16'h0000;
    new_sample_ready = 1'b0;
    target_gain      = 5'd16;
    mute             = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(sample_to_codec), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_gain",  32'(current_gain), 32'd0);
    chk("rst_muted", 32'(muted), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rampup_state", 32'(muted), 32'd0);

    // 1: soft start at unity target
    for (int k = 1; k <= 20; k++) begin
      strobe("soft", 16'h1000, (k >= 17) ? 16'h1000 : 16'((k - 1) * 256));
      chk("soft_gain", 32'(current_gain), 32'((k > 16) ? 16 : k));
    end
    chk("play_muted", 32'(muted), 32'd0);

    // 2: ramp down to gain 8, then floor-shift cases
    target_gain = 5'd8;
    for (int k = 1; k <= 8; k++) strobe("down8", 16'h0000, 16'h0000);
    chk("gain8", 32'(current_gain), 32'd8);
    strobe("g8_min",  16'h8000, 16'hC000);
    strobe("g8_3",    16'h0003, 16'h0001);
    strobe("g8_m1",   16'hFFFF, 16'hFFFF);
    strobe("g8_max",  16'h7FFF, 16'h3FFF);

    // 3: ramp up to full boost, saturation both ways
    target_gain = 5'd31;
    for (int k = 1; k <= 23; k++) strobe("up31", 16'h0000, 16'h0000);
    chk("gain31", 32'(current_gain), 32'd31);
    strobe("g31_pos", 16'h7000, 16'h7FFF);
    strobe("g31_neg", 16'h9000, 16'h8000);
    strobe("g31_16",  16'h0010, 16'h001F);

    // 4: back to unity, then mute fade-out and fade-in
    target_gain = 5'd16;
    for (int k = 1; k <= 15; k++) strobe("down16", 16'h0000, 16'h0000);
    chk("gain16", 32'(current_gain), 32'd16);
    mute = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      strobe("fade", 16'h1000, 16'((17 - k) * 256));
      chk("fade_gain", 32'(current_gain), 32'(16 - k));
    end
    chk("mute_state", 32'(muted), 32'd1);
    strobe("mute_max", 16'h7FFF, 16'h0000);
    strobe("mute_min", 16'h8000, 16'h0000);
    chk("mute_gain", 32'(current_gain), 32'd0);
    mute = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("unmute_state", 32'(muted), 32'd0);
    strobe("unmute", 16'h1000, 16'h0000);
    chk("unmute_gain", 32'(current_gain), 32'd1);

    // 5: level held high yields one strobe per rising edge
    pulses = 0;
    sample_in        = 16'h0100;
    new_sample_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    new_sample_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    new_sample_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    new_sample_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_gain",   32'(current_gain), 32'd3);
    chk("held_data",   32'(sample_to_codec), 32'h0020);

    // 6: reset between strobe and its output
    sample_in        = 16'h1000;
    new_sample_ready = 1'b1;
    @(negedge clk);
    new_sample_ready = 1'b0;
    reset_n          = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_valid", 32'(sample_valid), 32'd0);
    chk("abort_data",  32'(sample_to_codec), 32'd0);
    chk("abort_gain",  32'(current_gain), 32'd0);
    chk("abort_muted", 32'(muted), 32'd1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    chk("abort_nopulse", 32'(pulses), 32'd0);
    chk("abort_gain2",   32'(current_gain), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
